mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the execute stage and the word-addressed `data_memory` array. It accepts one byte-addressed load or store at a time and issues the word read or write on the memory port. Sub-word stores use read-modify-write; sub-word loads return the selected lane, zero- or sign-extended. It returns one response per request to the pipeline.

## Interface
- `ADDR_W`, default 10: word-address width. The byte address is `ADDR_W+2` bits.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in `ADDR_W+2`: byte address, little-endian lanes (offset 0 = bits 7:0).
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access (only when the trap is compiled in).
- `mem_address` out `ADDR_W`: word address to memory.
- `mem_data` out 32: write word to memory.
- `mem_we` out 1: memory write enable.
- `mem_q` in 32: combinational read data from memory at `mem_address`.

## Operation
- **FSM states:** IDLE, LOAD, RMW_RD, WRITE, RESP.
- **Accept:** `req_valid & req_ready` at a rising edge. On accept, the unit registers the address, size, data and flags.
  - Load goes to LOAD.
  - Word store goes to WRITE.
  - Byte/half store goes to RMW_RD.
  - Misaligned request goes to RESP with `resp_err`=1.
- **LOAD:** `mem_address` = registered `addr[ADDR_W+1:2]`. The lane is extracted from `mem_q` and captured into `resp_rdata`. Next state RESP.
  - Byte: lane `addr[1:0]`.
  - Half: `addr[1]` selects bits 15:0 or 31:16.
- **RMW_RD:** `mem_q` is captured into the merge register. Next state WRITE.
- **WRITE:** `mem_we`=1. `mem_data` is one of:
  - `req_wdata` for a word store;
  - the captured word with `wdata[7:0]` or `wdata[15:0]` replacing the addressed lane.
  - Next state RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE.
- **Misaligned:** a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- **Memory-port outputs:**
  - `mem_we` is decoded from state only.
  - `mem_address` and `mem_data` are registered and hold their last value outside active states.
- **Reset:** `RST_N` low forces IDLE immediately, mid-operation included. `mem_we` drops in the same instant and no partial write completes.
- **Reset values:**
  - `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `mem_we`=0, `mem_address`=0, `mem_data`=0.
  - Merge register = 0.

## Timing
- Let E0 be the accept edge.
- **Load:** LOAD during E0–E1, data captured at E1. `resp_valid` high E1–E2. `req_ready` high again after E2. Accept-to-response is 1 cycle; throughput is 1 request per 3 cycles.
- **Word store:** `mem_we` high E0–E1, memory written at E1. Response E1–E2.
- **Sub-word store:** read E0–E1, `mem_we` high E1–E2, write at E2. Response E2–E3.
- **Error:** response E0–E1; no memory cycle at all.
- **Request lines:** `req_valid` seen outside IDLE is ignored. The request stays pending until `req_ready`. Request inputs are sampled only at the accept edge.
- **Address wrap:** addresses wrap naturally within `ADDR_W` bits. There is no bounds check.

## Configuration
- `MAU_MISALIGN_TRAP_EN`
- **Defined:** misaligned requests give an error response (`resp_err`=1, `resp_rdata`=0). Memory is untouched.
- **Undefined:** `resp_err` is tied to 0. Misaligned addresses are aligned down before use:
  - half: `addr[0]` cleared;
  - word: `addr[1:0]` cleared.

## Test plan
- **Word store then load:** store `0xDEADBEEF` @0x010, then signed-word load @0x010.
  - Required: `mem_we` is high for exactly 1 cycle at word 4.
  - Required: the load returns `0xDEADBEEF` with `resp_valid` 1 cycle after accept.
- **Byte store RMW:** memory word 4 = `0x11223344`; store byte `0xAA` @0x012.
  - Required: word 4 = `0x11AA3344`.
  - Required: `mem_we` is high only in the second post-accept cycle.
- **Sign-extension:** load byte @0x012 signed → `0xFFFFFFAA`; unsigned → `0x000000AA`. Load half @0x012 signed → `0x000011AA`.
- **Misaligned, trap defined:** half load @0x013 → `resp_err`=1 and `resp_rdata`=0, response in the cycle after accept.
  - Word store @0x011 → `resp_err`=1 and `mem_we` never asserted.
  - Trap undefined: the same word store writes word 4.
- **Reset in RMW_RD:** assert `RST_N` low during RMW_RD of a byte store.
  - Required: no write occurs and word 4 is unchanged.
  - Required: after release, `req_ready`=1, `resp_valid`=0, and all outputs are at reset values.
- **Back-to-back:** hold `req_valid` high with 3 queued loads.
  - Required: accepts occur every 3 cycles.
  - Required: exactly 3 `resp_valid` pulses, in order.
  - Required: `req_ready` is low outside IDLE.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Request/response and word-memory port bundle for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data;
    logic              mem_we;
    logic [31:0]       mem_q;

    // Pipeline plus memory side of the unit.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_data, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Byte-addressed load/store sequencer onto a word memory, with
//            read-modify-write for sub-word stores. Optional misalignment
//            trap selected by macro MAU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_data;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [15:0]       r_wdata;
    logic [1:0]        w_off;
    logic              w_trap;

    // Lane offset after aligning halves/words down to their natural boundary.
    always_comb begin
        w_off = bus.req_addr[1:0];
        if (bus.req_size == 2'b01) begin
            w_off[0] = 1'b0;
        end else if (bus.req_size[1]) begin
            w_off = 2'b00;
        end
    end

`ifdef MAU_MISALIGN_TRAP_EN
    logic r_resp_err;
    assign w_trap       = (w_off != bus.req_addr[1:0]);
    assign bus.resp_err = r_resp_err;
`else
    assign w_trap       = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] q, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = q[{off, 3'b000} +: 8];
        h = off[1] ? q[31:16] : q[15:0];
        case (sz)
            2'b00:   extract = {{24{b[7] & ~uns}}, b};
            2'b01:   extract = {{16{h[15] & ~uns}}, h};
            default: extract = q;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] q, input logic [15:0] wd,
                                          input logic is_half, input logic [1:0] off);
        merge = q;
        if (is_half) begin
            if (off[1]) merge[31:16] = wd;
            else        merge[15:0]  = wd;
        end else begin
            merge[{off, 3'b000} +: 8] = wd[7:0];
        end
    endfunction

    // The mem_data register doubles as the merge register: the merged word
    // is captured straight from mem_q so it is ready for the WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_off         <= '0;
            r_size        <= '0;
            r_unsigned    <= 1'b0;
            r_wdata       <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            r_resp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_ready    <= 1'b0;
                        r_off      <= w_off;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata[15:0];
                        if (w_trap) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
                            r_resp_err   <= 1'b1;
`endif
                            r_state      <= S_RESP;
                        end else begin
                            r_mem_address <= bus.req_addr[ADDR_W+1:2];
                            if (!bus.req_we) begin
                                r_state <= S_LOAD;
                            end else if (bus.req_size[1]) begin
                                r_mem_data <= bus.req_wdata;
                                r_state    <= S_WRITE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= extract(bus.mem_q, r_size, r_off, r_unsigned);
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RMW_RD: begin
                    r_mem_data <= merge(bus.mem_q, r_wdata, r_size[0], r_off);
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_resp_rdata <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
                    r_resp_err   <= 1'b0;
`endif
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data    = r_mem_data;
    assign bus.mem_we      = (r_state == S_WRITE);

endmodule

`default_nettype wire
